// File: rtl/skinny_mode_ctrl.sv
// skinny_mode_ctrl
// Sequencer for the masked Romulus-N mode datapath: serial load of state and
// tweakeys, masked Skinny-128-384+ rounds, tweakey revert with counter step,
// and serial unload. Both shares are driven by the same strobes.
module skinny_mode_ctrl #(
   parameter int unsigned NUM_ROUNDS = 40,
   parameter int unsigned ROUND_LAT  = 4,
   parameter int unsigned WORDS      = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       ld_s,
   input  logic       ld_y,
   input  logic       ld_x,
   input  logic       use_tk1,
   input  logic [7:0] domain_i,
   input  logic [3:0] decrypt_i,
   input  logic       cnt_inc,
   input  logic       pdi_valid,
   output logic       pdi_ready,
   input  logic       sdi_valid,
   output logic       sdi_ready,
   output logic       pdo_valid,
   input  logic       pdo_ready,
   output logic       busy,
   output logic       done,
   output logic       srst,
   output logic       senc,
   output logic       sse,
   output logic       xrst,
   output logic       xenc,
   output logic       xse,
   output logic       yrst,
   output logic       yenc,
   output logic       yse,
   output logic       zrst,
   output logic       zenc,
   output logic       zse,
   output logic       correct_cnt,
   output logic       tk1s,
   output logic [5:0] constant,
   output logic [7:0] domain,
   output logic [3:0] decrypt
);

   localparam int unsigned RW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
   localparam int unsigned PW = (ROUND_LAT  > 1) ? $clog2(ROUND_LAT)  : 1;
   localparam int unsigned WW = (WORDS      > 1) ? $clog2(WORDS)      : 1;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_INIT   = 3'd1;
   localparam logic [2:0] ST_LD_S   = 3'd2;
   localparam logic [2:0] ST_LD_Y   = 3'd3;
   localparam logic [2:0] ST_LD_X   = 3'd4;
   localparam logic [2:0] ST_ROUND  = 3'd5;
   localparam logic [2:0] ST_REVERT = 3'd6;
   localparam logic [2:0] ST_OUT    = 3'd7;

   // Strobe vector bit order: {srst,senc,sse,xrst,xenc,xse,yrst,yenc,yse,zrst,zenc,zse}
   localparam logic [11:0] STB_SHIFT_S = 12'h600;
   localparam logic [11:0] STB_SHIFT_X = 12'h0C0;
   localparam logic [11:0] STB_SHIFT_Y = 12'h018;
   localparam logic [11:0] STB_COMMIT  = 12'h492;
   localparam logic [11:0] STB_REVERT  = 12'h1B6;
   localparam logic [11:0] STB_CNT     = 12'h006;

   logic [2:0]    state_q, state_d;
   logic [WW-1:0] word_q;
   logic [RW-1:0] round_q;
   logic [PW-1:0] phase_q;
   logic [5:0]    const_q;
   logic [7:0]    dom_q;
   logic [3:0]    dec_q;
   logic          f_ld_s, f_ld_y, f_ld_x, f_tk1;
   logic          done_q;

   logic          pdi_hs, sdi_hs, pdo_hs, word_hs;
   logic          last_word, last_phase, last_round;
   logic [2:0]    after_init, after_s, after_y;
   logic [11:0]   stb;
   logic          cc;

   function automatic logic [5:0] lfsr_step(input logic [5:0] c);
      return {c[4:0], c[5] ^ c[4] ^ 1'b1};
   endfunction

   assign pdi_ready = (state_q == ST_LD_S) || (state_q == ST_LD_Y);
   assign sdi_ready = (state_q == ST_LD_X);
   assign pdo_valid = (state_q == ST_OUT);

   assign pdi_hs  = pdi_valid & pdi_ready;
   assign sdi_hs  = sdi_valid & sdi_ready;
   assign pdo_hs  = pdo_valid & pdo_ready;
   assign word_hs = pdi_hs | sdi_hs | pdo_hs;

   assign last_word  = (word_q  == WW'(WORDS - 1));
   assign last_phase = (phase_q == PW'(ROUND_LAT - 1));
   assign last_round = (round_q == RW'(NUM_ROUNDS - 1));

   // Disabled loads are skipped entirely, so each exit resolves the chain here.
   assign after_y    = f_ld_x ? ST_LD_X : ST_ROUND;
   assign after_s    = f_ld_y ? ST_LD_Y : after_y;
   assign after_init = f_ld_s ? ST_LD_S : after_s;

   // Next-state selection
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_INIT;
         ST_INIT:   state_d = after_init;
         ST_LD_S:   if (pdi_hs && last_word) state_d = after_s;
         ST_LD_Y:   if (pdi_hs && last_word) state_d = after_y;
         ST_LD_X:   if (sdi_hs && last_word) state_d = ST_ROUND;
         ST_ROUND:  if (last_phase && last_round) state_d = ST_REVERT;
         ST_REVERT: state_d = ST_OUT;
         ST_OUT:    if (pdo_hs && last_word) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Datapath strobes from state and same-cycle handshake
   always_comb begin
      stb = '0;
      cc  = 1'b0;
      case (state_q)
         ST_IDLE: if (cnt_inc && !start) begin
            stb = STB_CNT;
            cc  = 1'b1;
         end
         ST_LD_S:   if (pdi_hs) stb = STB_SHIFT_S;
         ST_LD_Y:   if (pdi_hs) stb = STB_SHIFT_Y;
         ST_LD_X:   if (sdi_hs) stb = STB_SHIFT_X;
         ST_ROUND:  if (last_phase) stb = STB_COMMIT;
         ST_REVERT: stb = STB_REVERT;
         ST_OUT:    if (pdo_hs) stb = STB_SHIFT_S;
         default:   stb = '0;
      endcase
   end

   // Strobes are suppressed in a reset cycle so no register sees a partial update.
   assign {srst, senc, sse, xrst, xenc, xse, yrst, yenc, yse, zrst, zenc, zse} =
          stb & {12{rst_n}};
   assign correct_cnt = cc & rst_n;

   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;
   assign tk1s     = (state_q == ST_ROUND) & f_tk1;
   assign constant = const_q;
   assign domain   = busy ? dom_q : '0;
   assign decrypt  = (state_q == ST_OUT) ? dec_q : '0;

   // State, counters, latched command and round constant
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         word_q  <= '0;
         round_q <= '0;
         phase_q <= '0;
         const_q <= '0;
         dom_q   <= '0;
         dec_q   <= '0;
         f_ld_s  <= 1'b0;
         f_ld_y  <= 1'b0;
         f_ld_x  <= 1'b0;
         f_tk1   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == ST_OUT) && pdo_hs && last_word;

         if (state_q == ST_IDLE && start) begin
            f_ld_s <= ld_s;
            f_ld_y <= ld_y;
            f_ld_x <= ld_x;
            f_tk1  <= use_tk1;
            dom_q  <= domain_i;
            dec_q  <= decrypt_i;
         end

         if (word_hs) word_q <= last_word ? '0 : word_q + WW'(1);

         if (state_q == ST_ROUND) begin
            if (last_phase) begin
               phase_q <= '0;
               round_q <= last_round ? '0 : round_q + RW'(1);
            end else begin
               phase_q <= phase_q + PW'(1);
            end
         end

         // Entry into ROUND starts the sequence from zero so round 1 sees 0x01.
         if (state_q != ST_ROUND && state_d == ST_ROUND)
            const_q <= lfsr_step('0);
         else if (state_q == ST_ROUND && last_phase)
            const_q <= lfsr_step(const_q);
         else if (state_q == ST_INIT || state_d == ST_IDLE)
            const_q <= '0;
      end
   end

endmodule

// File: tb/tb_skinny_mode_ctrl.sv
// tb_skinny_mode_ctrl
// Directed bench: a scenario generator builds per-cycle stimulus and expected
// outputs from the operational rules; one play loop drives and compares.
module tb_skinny_mode_ctrl;

   localparam int NR = 40;
   localparam int RL = 4;
   localparam int NW = 4;

   localparam logic [11:0] M_SHIFT_S = 12'h600;
   localparam logic [11:0] M_SHIFT_X = 12'h0C0;
   localparam logic [11:0] M_SHIFT_Y = 12'h018;
   localparam logic [11:0] M_COMMIT  = 12'h492;
   localparam logic [11:0] M_REVERT  = 12'h1B6;
   localparam logic [11:0] M_CNT     = 12'h006;

   typedef struct packed {
      logic       rst_n, start, ld_s, ld_y, ld_x, use_tk1;
      logic [7:0] dom;
      logic [3:0] dec;
      logic       cnt_inc, pdi_valid, sdi_valid, pdo_ready;
   } stim_t;

   typedef struct packed {
      logic        busy, done, pdi_ready, sdi_ready, pdo_valid;
      logic [11:0] strb;
      logic        correct_cnt, tk1s;
      logic [5:0]  constant;
      logic [7:0]  domain;
      logic [3:0]  decrypt;
   } obs_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n = 1'b0, start = 1'b0, ld_s = 1'b0, ld_y = 1'b0, ld_x = 1'b0;
   logic       use_tk1 = 1'b0, cnt_inc = 1'b0;
   logic       pdi_valid = 1'b0, sdi_valid = 1'b0, pdo_ready = 1'b0;
   logic [7:0] domain_i = '0;
   logic [3:0] decrypt_i = '0;
   logic       pdi_ready, sdi_ready, pdo_valid, busy, done;
   logic       srst, senc, sse, xrst, xenc, xse, yrst, yenc, yse, zrst, zenc, zse;
   logic       correct_cnt, tk1s;
   logic [5:0] constant;
   logic [7:0] domain;
   logic [3:0] decrypt;

   skinny_mode_ctrl #(.NUM_ROUNDS(NR), .ROUND_LAT(RL), .WORDS(NW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ld_s(ld_s), .ld_y(ld_y), .ld_x(ld_x),
      .use_tk1(use_tk1), .domain_i(domain_i), .decrypt_i(decrypt_i), .cnt_inc(cnt_inc),
      .pdi_valid(pdi_valid), .pdi_ready(pdi_ready), .sdi_valid(sdi_valid), .sdi_ready(sdi_ready),
      .pdo_valid(pdo_valid), .pdo_ready(pdo_ready), .busy(busy), .done(done),
      .srst(srst), .senc(senc), .sse(sse), .xrst(xrst), .xenc(xenc), .xse(xse),
      .yrst(yrst), .yenc(yenc), .yse(yse), .zrst(zrst), .zenc(zenc), .zse(zse),
      .correct_cnt(correct_cnt), .tk1s(tk1s), .constant(constant),
      .domain(domain), .decrypt(decrypt)
   );

   stim_t sq[$];
   obs_t  eq[$];
   bit    cq[$];

   int n_chk  = 0;
   int n_pass = 0;

   // observations gathered during play, used by the literal checks
   int         done_off;
   int         n_commit;
   int         first_commit;
   int         bad_spacing;
   logic [5:0] rnd_const[10];

   function automatic logic [5:0] lfsr(input logic [5:0] c);
      return {c[4:0], c[5] ^ c[4] ^ 1'b1};
   endfunction

   function automatic stim_t idle_s();
      stim_t s = '0;
      s.rst_n = 1'b1;
      return s;
   endfunction

   task automatic push(input stim_t s, input obs_t e, input bit c);
      sq.push_back(s);
      eq.push_back(e);
      cq.push_back(c);
   endtask

   task automatic gen_reset(input int n);
      stim_t s = '0;
      for (int i = 0; i < n; i++) push(s, '0, 1'b0);
   endtask

   task automatic gen_idle(input int n);
      for (int i = 0; i < n; i++) push(idle_s(), '0, 1'b1);
   endtask

   task automatic gen_cnt_inc();
      stim_t s = idle_s();
      obs_t  e = '0;
      s.cnt_inc = 1'b1;
      e.strb = M_CNT;
      e.correct_cnt = 1'b1;
      push(s, e, 1'b1);
   endtask

   // One serial load of NW words, each preceded by 'gap' idle-valid cycles.
   task automatic gen_load(input int which, input int gap, input obs_t b);
      stim_t s;
      obs_t  e;
      for (int w = 0; w < NW; w++) begin
         for (int g = 0; g <= gap; g++) begin
            s = idle_s();
            e = b;
            if (which == 2) e.sdi_ready = 1'b1; else e.pdi_ready = 1'b1;
            if (g == gap) begin
               if (which == 2) s.sdi_valid = 1'b1; else s.pdi_valid = 1'b1;
               e.strb = (which == 0) ? M_SHIFT_S : (which == 1) ? M_SHIFT_Y : M_SHIFT_X;
            end
            push(s, e, 1'b1);
         end
      end
   endtask

   task automatic gen_block(input bit ls, input bit ly, input bit lx, input bit tk,
                            input logic [7:0] dm, input logic [3:0] dc, input int gap,
                            input int pdo_stall, input bit with_cnt, input int abort_round);
      stim_t      s;
      obs_t       e, b;
      logic [5:0] c;
      s = idle_s();
      s.start = 1'b1; s.ld_s = ls; s.ld_y = ly; s.ld_x = lx; s.use_tk1 = tk;
      s.dom = dm; s.dec = dc; s.cnt_inc = with_cnt;
      push(s, '0, 1'b1);
      b = '0;
      b.busy = 1'b1;
      b.domain = dm;
      push(idle_s(), b, 1'b1);
      if (ls) gen_load(0, gap, b);
      if (ly) gen_load(1, gap, b);
      if (lx) gen_load(2, gap, b);
      c = lfsr(6'd0);
      for (int r = 0; r < NR; r++) begin
         for (int p = 0; p < RL; p++) begin
            s = idle_s();
            e = b;
            e.tk1s = tk;
            e.constant = c;
            if (p == RL - 1) e.strb = M_COMMIT;
            if (r == 5 && p == 0) begin
               s.start = 1'b1;
               s.cnt_inc = 1'b1;
               s.dom = ~dm;
            end
            if (r == abort_round && p == RL - 1) begin
               s.rst_n = 1'b0;
               e.strb = '0;
               push(s, e, 1'b1);
               gen_idle(1);
               return;
            end
            push(s, e, 1'b1);
            if (p == RL - 1) c = lfsr(c);
         end
      end
      e = b;
      e.constant = c;
      e.strb = M_REVERT;
      push(idle_s(), e, 1'b1);
      for (int w = 0; w < NW; w++) begin
         for (int k = 0; k <= ((w == 0) ? pdo_stall : 0); k++) begin
            s = idle_s();
            e = b;
            e.constant = c;
            e.pdo_valid = 1'b1;
            e.decrypt = dc;
            if (k == ((w == 0) ? pdo_stall : 0)) begin
               s.pdo_ready = 1'b1;
               e.strb = M_SHIFT_S;
            end
            push(s, e, 1'b1);
         end
      end
      e = '0;
      e.done = 1'b1;
      push(idle_s(), e, 1'b1);
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Drives each queued cycle after the edge and compares mid-cycle.
   task automatic play(input string name);
      obs_t a;
      int   t0 = 0;
      done_off = -1; n_commit = 0; first_commit = -1; bad_spacing = 0;
      for (int i = 0; i < sq.size(); i++) begin
         @(posedge clk);
         #1;
         {rst_n, start, ld_s, ld_y, ld_x, use_tk1, domain_i, decrypt_i,
          cnt_inc, pdi_valid, sdi_valid, pdo_ready} = sq[i];
         if (sq[i].start && sq[i].rst_n && i < 2 + NW) t0 = i;
         @(negedge clk);
         a.busy = busy; a.done = done; a.pdi_ready = pdi_ready;
         a.sdi_ready = sdi_ready; a.pdo_valid = pdo_valid;
         a.strb = {srst, senc, sse, xrst, xenc, xse, yrst, yenc, yse, zrst, zenc, zse};
         a.correct_cnt = correct_cnt; a.tk1s = tk1s; a.constant = constant;
         a.domain = domain; a.decrypt = decrypt;
         if (cq[i]) begin
            n_chk++;
            if (a === eq[i]) n_pass++;
            else $display("FAIL %s cycle %0d: got %h expected %h", name, i, a, eq[i]);
         end
         if (done === 1'b1) done_off = i - t0;
         if (senc === 1'b1 && xenc === 1'b1 && xse === 1'b0) begin
            if (first_commit < 0) first_commit = i;
            else if ((i - first_commit) % RL != 0) bad_spacing++;
            if (n_commit < 10) rnd_const[n_commit] = constant;
            n_commit++;
         end
      end
      sq.delete();
      eq.delete();
      cq.delete();
   endtask

   initial begin
      logic [5:0] const_ref[10];
      const_ref = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F};

      gen_reset(3);
      gen_idle(2);
      play("reset");

      // full block, all loads, no stalls
      gen_block(1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 4'h3, 0, 0, 1'b0, -1);
      gen_idle(2);
      play("full");
      chk_int("full done latency", done_off, 179);
      chk_int("full commit count", n_commit, 40);
      chk_int("full commit spacing", bad_spacing, 0);
      for (int r = 0; r < 10; r++)
         chk_int($sformatf("round %0d constant", r + 1), int'(rnd_const[r]), int'(const_ref[r]));

      // counter-only increment, then start with cnt_inc and a toggling pdi_valid
      gen_cnt_inc();
      gen_idle(1);
      gen_block(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 4'h9, 1, 0, 1'b1, -1);
      gen_idle(1);
      play("state-only");
      chk_int("state-only done latency", done_off, 175);

      // reset in round 17, then a fresh block with an unload stall
      gen_block(1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 4'h6, 0, 0, 1'b0, 16);
      gen_idle(2);
      play("abort");
      gen_block(1'b1, 1'b0, 1'b1, 1'b0, 8'h81, 4'hC, 0, 10, 1'b0, -1);
      gen_idle(2);
      play("restart");
      chk_int("restart done latency", done_off, 185);
      chk_int("restart commit count", n_commit, 40);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/skinny_mode_ctrl.md
# skinny_mode_ctrl

Sequencer for the first-order masked Romulus-N mode datapath. It owns every strobe of the shared Skinny-128-384+ round datapath: serial state/tweakey loading, 40 masked rounds, the single-cycle tweakey revert with counter step, and serial ciphertext/plaintext unload. It sits between the LWC controller (handshakes) and the masked mode datapath (strobes), driving both shares' registers with the same control.

## Interface
Parameters:
- NUM_ROUNDS, 40, Skinny rounds per block call
- ROUND_LAT, 4, cycles per masked round (HPC2 gadget latency); ≥1
- WORDS, 4, 32-bit words per 128-bit register

Ports:
- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  pulse; accepted only in IDLE
- ld_s, ld_y, ld_x  in  1 each  sampled with start; load state / TK-Y / TK-X
- use_tk1  in  1  sampled with start; include counter tweakey in rounds
- domain_i  in  8  sampled with start
- decrypt_i  in  4  sampled with start
- cnt_inc  in  1  pulse in IDLE: counter-only increment
- pdi_valid / pdi_ready  in / out  1  word handshake for state and TK-Y
- sdi_valid / sdi_ready  in / out  1  word handshake for TK-X
- pdo_valid / pdo_ready  out / in  1  unload handshake
- busy, done  out  1  done: one-cycle pulse
- srst, senc, sse, xrst, xenc, xse, yrst, yenc, yse, zrst, zenc, zse  out  1  datapath strobes
- correct_cnt, tk1s  out  1
- constant  out  6  round constant
- domain  out  8;  decrypt  out  4

## Operation
- Register strobe encoding (per register r): renc=1,rse=1 shift in serial word; renc=1,rse=0 load round output; rrst=1,renc=1 load revert value; rrst=1,renc=0 clear. All zero = hold.
- FSM: IDLE → INIT → LD_S → LD_Y → LD_X → ROUND → REVERT → OUT → IDLE. Load states with flag 0 are skipped (zero cycles).
- IDLE: busy=0, all strobes 0. start → INIT, latch flags/domain/decrypt. cnt_inc (without start) → single cycle zrst=1,zenc=1,correct_cnt=1 (counter LFSR step on unpermuted value), stays IDLE. start and cnt_inc together: start wins, cnt_inc dropped.
- INIT: one cycle, busy=1, constant cleared to 0.
- LD_S / LD_Y: pdi_ready=1; each pdi_valid&pdi_ready asserts sse,senc (resp. yse,yenc) that cycle; word counter 0..WORDS-1; leave after WORDS-th handshake.
- LD_X: same with sdi_valid/sdi_ready, xse,xenc.
- ROUND: round counter 0..NUM_ROUNDS-1, phase counter 0..ROUND_LAT-1. On phase ROUND_LAT-1: senc,xenc,yenc,zenc=1 (se=0), constant advances. tk1s=use_tk1 throughout ROUND.
- constant: 6-bit LFSR c' = {c[4:0], c[5]^c[4]^1}; advanced at INIT→ROUND entry from 0 (first round sees 0x01) and after each round's commit.
- REVERT: one cycle, xrst,xenc,yrst,yenc,zrst,zenc=1, correct_cnt=0 (counter steps on permuted value).
- OUT: decrypt=latched decrypt_i, pdo_valid=1; each pdo_valid&pdo_ready asserts sse,senc. After WORDS-th handshake → IDLE, done=1 next cycle.
- domain = latched domain_i from INIT until IDLE; 0 in IDLE. decrypt = 0 outside OUT.
- start while busy: ignored. cnt_inc while busy: ignored.

## Timing
- Reset (rst_n=0 at edge): state IDLE, all outputs 0 including constant, domain, decrypt, busy, done, all ready/valid; counters 0. Applies mid-operation; no partial strobe issued in the reset cycle.
- Readys/valids are combinational from state only; strobes combinational from state and handshake of the same cycle.
- No-stall latency, all loads on: start at cycle 0 → INIT 1, LD_S 2–5, LD_Y 6–9, LD_X 10–13, ROUND 14–173, REVERT 174, OUT 175–178, done=1 at 179.
- Each skipped load subtracts WORDS cycles. Stalls (valid/ready low) extend the current state only; counters hold.
- Round counter wraps to 0 on ROUND exit; word counter wraps to 0 on each load/unload exit.

## Test plan
- Full block, no stalls, ld_s=ld_y=ld_x=1 → busy 1..178, done at cycle 179, exactly 40 senc pulses in ROUND spaced 4 cycles.
- Constant trace → 0x01,0x03,0x07,0x0F,0x1F,0x3E,0x3D,0x3B,0x37,0x2F for rounds 1–10; 0 in IDLE.
- ld_y=ld_x=0, pdi_valid toggled every other cycle → only 4 sse pulses, LD_Y/LD_X skipped, done at 171+stall cycles.
- cnt_inc in IDLE → one cycle zrst=zenc=correct_cnt=1, busy stays 0; cnt_inc with start → no counter-only step.
- rst_n=0 during ROUND round 17 → next cycle IDLE, constant=0, all strobes 0; new start completes normally.
- pdo_ready held 0 for 10 cycles in OUT → pdo_valid held, no senc, decrypt=decrypt_i held, done delayed 10 cycles.
